quad_position_counter: RTL and testbench

QUAD_POSITION_COUNTER -- requirements
Module: quad_position_counter

---
 rtl/quad_position_counter.sv | 195 +++++++++++++++++++
 tb/tb_quad_position_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_position_counter.sv
// ---------------------------------------------------------------------------
// quad_position_counter
//
// Position counter fed by a quadrature decoder's count-enable pulses. In fine
// mode every pulse moves the position by one. In coarse mode a signed
// prescaler collects PRESCALE pulses per step. The position saturates
// (inclusive) at lim_lo/lim_hi and never wraps. Every position change is
// published through a valid/ready snapshot port; a snapshot replaced before it
// was accepted raises a sticky overrun flag.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset (highest priority)
//   cnt, dir   count pulse and its direction (1 = up, 0 = down)
//   mode       0 = fine, 1 = coarse
//   clr        clear position, prescaler, snapshot valid and overrun
//   load       preload position from load_val (below clr, above cnt)
//   load_val   preload value (signed)
//   lim_hi/lo  inclusive signed saturation limits
//   pos        registered position
//   at_hi/lo   registered pos==lim_hi / pos==lim_lo (one cycle behind pos)
//   lim_err    registered lim_lo > lim_hi
//   pos_valid  snapshot available, pos_ready accepts it
//   pos_snap   snapshot value
//   overrun    sticky: snapshot overwritten while unaccepted
// ---------------------------------------------------------------------------
module quad_position_counter #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cnt,
  input  logic                    dir,
  input  logic                    mode,
  input  logic                    clr,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] load_val,
  input  logic signed [WIDTH-1:0] lim_hi,
  input  logic signed [WIDTH-1:0] lim_lo,
  output logic signed [WIDTH-1:0] pos,
  output logic                    at_hi,
  output logic                    at_lo,
  output logic                    lim_err,
  output logic                    pos_valid,
  input  logic                    pos_ready,
  output logic signed [WIDTH-1:0] pos_snap,
  output logic                    overrun
);

  // Two extra bits so that +/-PRESCALE itself is representable before it is
  // folded back to zero.
  localparam int PW = $clog2(PRESCALE) + 2;
  localparam logic signed [PW-1:0] PS_MAX = PW'(PRESCALE);
  localparam logic signed [PW-1:0] PS_MIN = -PW'(PRESCALE);

  logic signed [PW-1:0]    presc_r;
  logic                    mode_r;
  logic                    chg_r;      // pos changed on the last edge

  logic signed [PW-1:0]    presc_base_s;
  logic signed [PW-1:0]    presc_cnt_s;
  logic signed [PW-1:0]    presc_next_s;
  logic                    step_up_s;
  logic                    step_dn_s;
  logic                    lim_bad_s;
  logic signed [WIDTH-1:0] count_pos_s;
  logic signed [WIDTH-1:0] pos_next_s;
  logic                    chg_next_s;

  // Prescaler / step decision and next position with clr > load > count.
  always_comb begin
    presc_base_s = '0;
    presc_cnt_s  = '0;
    presc_next_s = '0;
    step_up_s    = 1'b0;
    step_dn_s    = 1'b0;
    count_pos_s  = pos;
    pos_next_s   = pos;
    chg_next_s   = 1'b0;

    lim_bad_s = (lim_lo > lim_hi);

    // A mode change restarts accumulation from zero in the new mode.
    if (mode != mode_r) begin
      presc_base_s = '0;
    end else begin
      presc_base_s = presc_r;
    end

    if (!mode) begin
      presc_cnt_s  = '0;
      presc_next_s = '0;
      step_up_s    = cnt & dir;
      step_dn_s    = cnt & ~dir;
    end else begin
      if (cnt) begin
        if (dir) begin
          presc_cnt_s = presc_base_s + PW'(1);
        end else begin
          presc_cnt_s = presc_base_s - PW'(1);
        end
      end else begin
        presc_cnt_s = presc_base_s;
      end
      // Reaching +/-PRESCALE emits a step and folds back to zero, even when
      // the step itself is then swallowed by saturation.
      if (presc_cnt_s == PS_MAX) begin
        step_up_s    = 1'b1;
        presc_next_s = '0;
      end else if (presc_cnt_s == PS_MIN) begin
        step_dn_s    = 1'b1;
        presc_next_s = '0;
      end else begin
        presc_next_s = presc_cnt_s;
      end
    end

    if (step_up_s && !lim_bad_s && (pos < lim_hi)) begin
      count_pos_s = pos + WIDTH'(1);
    end else if (step_dn_s && !lim_bad_s && (pos > lim_lo)) begin
      count_pos_s = pos - WIDTH'(1);
    end else begin
      count_pos_s = pos;
    end

    // clr is not published as a change: it also discards the snapshot.
    if (clr) begin
      pos_next_s   = '0;
      presc_next_s = '0;
      chg_next_s   = 1'b0;
    end else if (load) begin
      pos_next_s   = load_val;
      presc_next_s = '0;
      chg_next_s   = (load_val != pos);
    end else begin
      pos_next_s   = count_pos_s;
      chg_next_s   = (count_pos_s != pos);
    end
  end

  // Position, prescaler, previous mode and change marker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos     <= '0;
      presc_r <= '0;
      mode_r  <= 1'b0;
      chg_r   <= 1'b0;
    end else begin
      pos     <= pos_next_s;
      presc_r <= presc_next_s;
      mode_r  <= mode;
      chg_r   <= chg_next_s;
    end
  end

  // Limit status flags, computed from the registered position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      at_hi   <= (lim_hi == '0);
      at_lo   <= (lim_lo == '0);
      lim_err <= (lim_lo > lim_hi);
    end else begin
      at_hi   <= (pos == lim_hi);
      at_lo   <= (pos == lim_lo);
      lim_err <= (lim_lo > lim_hi);
    end
  end

  // Snapshot handshake: a new change always wins over an accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_snap  <= '0;
      pos_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clr) begin
      pos_snap  <= pos_snap;
      pos_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (chg_r) begin
      pos_snap  <= pos;
      pos_valid <= 1'b1;
      overrun   <= overrun | (pos_valid & ~pos_ready);
    end else if (pos_valid && pos_ready) begin
      pos_snap  <= pos_snap;
      pos_valid <= 1'b0;
      overrun   <= overrun;
    end else begin
      pos_snap  <= pos_snap;
      pos_valid <= pos_valid;
      overrun   <= overrun;
    end
  end

endmodule

// File: tb/tb_quad_position_counter.sv
// ---------------------------------------------------------------------------
// Testbench for quad_position_counter: directed scenarios followed by random
// traffic, all checked against a cycle-level reference model built from
// integer arithmetic on position, prescaler count and snapshot state.
// ---------------------------------------------------------------------------
module tb_quad_position_counter;

  localparam int W = 16;
  localparam int P = 4;

  logic                clk = 1'b0;
  logic                rst_n, cnt, dir, mode, clr, load, pos_ready;
  logic signed [W-1:0] load_val, lim_hi, lim_lo;
  logic signed [W-1:0] pos, pos_snap;
  logic                at_hi, at_lo, lim_err, pos_valid, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_pos, m_presc, m_snap;
  bit m_mode, m_chg, m_valid, m_ovr, m_hi, m_lo, m_err;

  always #5 clk = ~clk;

  quad_position_counter #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .dir(dir), .mode(mode),
    .clr(clr), .load(load), .load_val(load_val),
    .lim_hi(lim_hi), .lim_lo(lim_lo),
    .pos(pos), .at_hi(at_hi), .at_lo(at_lo), .lim_err(lim_err),
    .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_snap(pos_snap), .overrun(overrun)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    int hi, lo, old, acc, step, nxt;
    hi  = int'(lim_hi);
    lo  = int'(lim_lo);
    old = m_pos;
    if (!rst_n) begin
      m_pos = 0; m_presc = 0; m_snap = 0; m_mode = 1'b0; m_chg = 1'b0;
      m_valid = 1'b0; m_ovr = 1'b0;
      m_hi = (hi == 0); m_lo = (lo == 0); m_err = (lo > hi);
      return;
    end
    m_hi  = (old == hi);
    m_lo  = (old == lo);
    m_err = (lo > hi);

    if (clr) begin
      m_valid = 1'b0; m_ovr = 1'b0;
    end else if (m_chg) begin
      if (m_valid && !pos_ready) m_ovr = 1'b1;
      m_snap = old; m_valid = 1'b1;
    end else if (m_valid && pos_ready) begin
      m_valid = 1'b0;
    end

    if (clr) begin
      m_pos = 0; m_presc = 0; m_chg = 1'b0;
    end else if (load) begin
      m_pos = int'(load_val); m_presc = 0; m_chg = (m_pos != old);
    end else begin
      step = 0;
      if (!mode) begin
        m_presc = 0;
        if (cnt) step = dir ? 1 : -1;
      end else begin
        acc = (mode != m_mode) ? 0 : m_presc;
        if (cnt) acc += dir ? 1 : -1;
        if (acc == P) begin
          step = 1; acc = 0;
        end else if (acc == -P) begin
          step = -1; acc = 0;
        end
        m_presc = acc;
      end
      nxt = old;
      if (lo <= hi) begin
        if (step == 1 && old < hi) nxt = old + 1;
        else if (step == -1 && old > lo) nxt = old - 1;
      end
      m_chg = (nxt != old);
      m_pos = nxt;
    end
    m_mode = mode;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("pos",       int'(pos),      m_pos);
    check_eq("pos_snap",  int'(pos_snap), m_snap);
    check_eq("pos_valid", int'(pos_valid), int'(m_valid));
    check_eq("overrun",   int'(overrun),  int'(m_ovr));
    check_eq("at_hi",     int'(at_hi),    int'(m_hi));
    check_eq("at_lo",     int'(at_lo),    int'(m_lo));
    check_eq("lim_err",   int'(lim_err),  int'(m_err));
  endtask

  task automatic pulses(input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      cnt = 1'b1; dir = d; tick();
    end
    cnt = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cnt = 1'b0; dir = 1'b0; mode = 1'b0; clr = 1'b0;
    load = 1'b0; load_val = '0; pos_ready = 1'b1;
    lim_hi = 16'sd1000; lim_lo = -16'sd1000;
    tick(); tick();
    check_eq("rst_pos", int'(pos), 0);
    check_eq("rst_valid", int'(pos_valid), 0);
    rst_n = 1'b1;
    tick();

    // fine counting with ready held high
    pulses(5, 1'b1);
    pulses(2, 1'b0);
    tick(); tick(); tick();
    check_eq("fine_pos", int'(pos), 3);
    check_eq("fine_snap", int'(pos_snap), 3);

    // coarse counting
    clr = 1'b1; tick(); clr = 1'b0;
    mode = 1'b1; tick();
    pulses(7, 1'b1); tick();
    check_eq("coarse7_pos", int'(pos), 1);
    pulses(1, 1'b1); tick();
    check_eq("coarse8_pos", int'(pos), 2);
    pulses(3, 1'b0);
    mode = 1'b0; tick();
    mode = 1'b1; tick();
    pulses(1, 1'b0); tick();
    check_eq("mode_toggle_pos", int'(pos), 2);

    // saturation at lim_hi and limit error blocking
    mode = 1'b0; lim_hi = 16'sd5;
    load = 1'b1; load_val = 16'sd4; tick(); load = 1'b0;
    pulses(3, 1'b1); tick();
    check_eq("sat_pos", int'(pos), 5);
    check_eq("sat_at_hi", int'(at_hi), 1);
    lim_lo = 16'sd10; tick();
    check_eq("lim_err", int'(lim_err), 1);
    pulses(3, 1'b0); tick();
    check_eq("err_hold_pos", int'(pos), 5);
    lim_lo = -16'sd1000; lim_hi = 16'sd1000; tick();

    // clr beats load and cnt, with a pending overrun/valid
    pos_ready = 1'b0;
    pulses(3, 1'b1); tick();
    clr = 1'b1; load = 1'b1; load_val = 16'sd77; cnt = 1'b1; dir = 1'b1;
    tick();
    clr = 1'b0; load = 1'b0; cnt = 1'b0;
    check_eq("prio_pos", int'(pos), 0);
    check_eq("prio_ovr", int'(overrun), 0);
    check_eq("prio_valid", int'(pos_valid), 0);
    tick();

    // overrun with consumer stalled
    pulses(3, 1'b1); tick(); tick();
    check_eq("ovr_snap", int'(pos_snap), 3);
    check_eq("ovr_valid", int'(pos_valid), 1);
    check_eq("ovr_flag", int'(overrun), 1);
    pos_ready = 1'b1; tick(); pos_ready = 1'b0;
    check_eq("ovr_accept_valid", int'(pos_valid), 0);
    check_eq("ovr_sticky", int'(overrun), 1);
    pos_ready = 1'b1;

    // reset in the middle of coarse accumulation
    mode = 1'b1;
    load = 1'b1; load_val = 16'sd7; tick(); load = 1'b0;
    pulses(2, 1'b1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_eq("mid_rst_pos", int'(pos), 0);
    check_eq("mid_rst_snap", int'(pos_snap), 0);
    check_eq("mid_rst_valid", int'(pos_valid), 0);
    pulses(4, 1'b1); tick();
    check_eq("resume_pos", int'(pos), 1);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        lim_hi = W'(int'($urandom_range(80)) - 20);
        lim_lo = W'(int'($urandom_range(80)) - 60);
      end
      rst_n     = ($urandom_range(499) != 0);
      clr       = ($urandom_range(39) == 0);
      load      = ($urandom_range(19) == 0);
      load_val  = W'(int'($urandom_range(120)) - 60);
      cnt       = ($urandom_range(1) == 1);
      dir       = ($urandom_range(99) < 55);
      if ($urandom_range(29) == 0) mode = ~mode;
      pos_ready = ($urandom_range(9) < 6);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
